// File: rtl/im_port_arbiter.sv
// rtl/im_port_arbiter.sv - two-requester arbiter in front of one shared asynchronous RAM port
// Optional macro IM_ARB_ROUND_ROBIN_EN: round-robin grant instead of fixed r0 priority.
module im_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic                    idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
  logic                    any_req;
  logic                    grant_idx;
  logic                    grant;

  assign any_req = r0_req | r1_req;
  assign grant   = (state_q == IDLE) && any_req;

`ifdef IM_ARB_ROUND_ROBIN_EN
  // last_q holds the index of the requester served most recently.
  logic last_q, last_d;

  always_comb begin
    if (r0_req && r1_req) begin
      grant_idx = ~last_q;
    end else begin
      grant_idx = ~r0_req;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant) begin
      last_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_idx = ~r0_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_cs = 1'b0;
    ram_we = 1'b0;
    ram_oe = 1'b0;
    r0_ack = 1'b0;
    r1_ack = 1'b0;
    busy   = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        ram_cs = 1'b1;
        ram_we = we_q;
        ram_oe = ~we_q;
      end
      RELEASE: begin
        r0_ack = ~idx_q;
        r1_ack = idx_q;
      end
      default: ;
    endcase
  end

  // The winner's request is frozen at grant time; later input changes are ignored.
  always_comb begin
    we_d     = we_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (grant) begin
      idx_d   = grant_idx;
      we_d    = grant_idx ? r1_we    : r0_we;
      addr_d  = grant_idx ? r1_addr  : r0_addr;
      wdata_d = grant_idx ? r1_wdata : r0_wdata;
    end
    if ((state_q == ACCESS) && !we_q) begin
      if (idx_q) begin
        rdata1_d = ram_rdata;
      end else begin
        rdata0_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      idx_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      we_q     <= we_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;
  assign r0_rdata    = rdata0_q;
  assign r1_rdata    = rdata1_q;

endmodule
